// File: rtl/enemy_missile_ctl.sv
// Enemy missile source: owns five missile slots, launches from the shooting enemy
// on a fixed period, moves live missiles down the screen and parks idle slots off-screen.
module enemy_missile_ctl #(
  parameter logic [31:0] FIRE_PERIOD = 32'd40_000_000,
  parameter logic [31:0] MOVE_DIV    = 32'd400_000,
  parameter logic [10:0] SPEED       = 11'd4,
  parameter logic [10:0] X_OFFSET    = 11'd14,
  parameter logic [10:0] Y_OFFSET    = 11'd32,
  parameter logic [10:0] Y_BOTTOM    = 11'd767,
  parameter logic [10:0] PARK        = 11'h7FF
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] enemy_x,
  input  logic [10:0] enemy_y,
  input  logic        enemy_alive,
  input  logic        ship_down,
  output logic [10:0] en_x_missile1,
  output logic [10:0] en_x_missile2,
  output logic [10:0] en_x_missile3,
  output logic [10:0] en_x_missile4,
  output logic [10:0] en_x_missile5,
  output logic [10:0] en_y_missile1,
  output logic [10:0] en_y_missile2,
  output logic [10:0] en_y_missile3,
  output logic [10:0] en_y_missile4,
  output logic [10:0] en_y_missile5,
  output logic [4:0]  active,
  output logic        fired
);

  localparam int unsigned NSLOT = 5;
  localparam int unsigned CW    = 11;
  localparam int unsigned TW    = 32;
  localparam logic [CW:0] SAT   = 12'h7FE;

  typedef enum logic {IDLE = 1'b0, FLYING = 1'b1} slot_state_t;

  slot_state_t   state_q [NSLOT];
  slot_state_t   state_d [NSLOT];
  logic [CW-1:0] x_q     [NSLOT];
  logic [CW-1:0] x_d     [NSLOT];
  logic [CW-1:0] y_q     [NSLOT];
  logic [CW-1:0] y_d     [NSLOT];
  logic [CW:0]   step_y  [NSLOT];

  logic [TW-1:0] fire_cnt, fire_cnt_d;
  logic [TW-1:0] move_cnt, move_cnt_d;
  logic          fire_tick, move_tick;
  logic          fired_d, launch_taken;
  logic [CW:0]   launch_x_sum, launch_y_sum;
  logic [CW-1:0] launch_x, launch_y;

  // Period counters; the fire counter is held at zero while the ship is down
  always_comb begin
    fire_tick  = (fire_cnt == FIRE_PERIOD - TW'(1)) && !ship_down;
    move_tick  = (move_cnt == MOVE_DIV - TW'(1));
    fire_cnt_d = fire_cnt + TW'(1);
    move_cnt_d = move_cnt + TW'(1);
    if (ship_down || fire_tick) fire_cnt_d = '0;
    if (move_tick)              move_cnt_d = '0;
  end

  // Launch position, saturated so a live missile never reads as PARK
  always_comb begin
    launch_x_sum = {1'b0, enemy_x} + {1'b0, X_OFFSET};
    launch_y_sum = {1'b0, enemy_y} + {1'b0, Y_OFFSET};
    launch_x     = (launch_x_sum > SAT) ? CW'(SAT) : launch_x_sum[CW-1:0];
    launch_y     = (launch_y_sum > SAT) ? CW'(SAT) : launch_y_sum[CW-1:0];
  end

  always_comb begin
    for (int k = 0; k < NSLOT; k++) step_y[k] = {1'b0, y_q[k]} + {1'b0, SPEED};
  end

  // Slot next-state: ship_down clears, flying slots step, lowest idle slot takes a launch
  always_comb begin
    fired_d      = 1'b0;
    launch_taken = 1'b0;
    for (int k = 0; k < NSLOT; k++) begin
      state_d[k] = state_q[k];
      x_d[k]     = x_q[k];
      y_d[k]     = y_q[k];
    end
    for (int k = 0; k < NSLOT; k++) begin
      if (ship_down) begin
        state_d[k] = IDLE;
        x_d[k]     = PARK;
        y_d[k]     = PARK;
      end else if (state_q[k] == FLYING) begin
        if (move_tick) begin
          if (step_y[k] > {1'b0, Y_BOTTOM}) begin
            state_d[k] = IDLE;
            x_d[k]     = PARK;
            y_d[k]     = PARK;
          end else begin
            y_d[k] = step_y[k][CW-1:0];
          end
        end
      end else if (fire_tick && enemy_alive && !launch_taken) begin
        state_d[k]   = FLYING;
        x_d[k]       = launch_x;
        y_d[k]       = launch_y;
        fired_d      = 1'b1;
        launch_taken = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      fire_cnt <= '0;
      move_cnt <= '0;
      fired    <= 1'b0;
      for (int k = 0; k < NSLOT; k++) begin
        state_q[k] <= IDLE;
        x_q[k]     <= PARK;
        y_q[k]     <= PARK;
      end
    end else begin
      fire_cnt <= fire_cnt_d;
      move_cnt <= move_cnt_d;
      fired    <= fired_d;
      for (int k = 0; k < NSLOT; k++) begin
        state_q[k] <= state_d[k];
        x_q[k]     <= x_d[k];
        y_q[k]     <= y_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NSLOT; k++) active[k] = (state_q[k] == FLYING);
  end

  assign en_x_missile1 = x_q[0];
  assign en_x_missile2 = x_q[1];
  assign en_x_missile3 = x_q[2];
  assign en_x_missile4 = x_q[3];
  assign en_x_missile5 = x_q[4];
  assign en_y_missile1 = y_q[0];
  assign en_y_missile2 = y_q[1];
  assign en_y_missile3 = y_q[2];
  assign en_y_missile4 = y_q[3];
  assign en_y_missile5 = y_q[4];

endmodule

// File: tb/tb_enemy_missile_ctl.sv
// Bench for enemy_missile_ctl: launch expectations are queued by the stimulus
// and checked by a monitor on every fired pulse; state snapshots checked inline.
module tb_enemy_missile_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] enemy_x, enemy_y;
  logic        enemy_alive, ship_down;
  logic [10:0] x1, x2, x3, x4, x5, y1, y2, y3, y4, y5;
  logic [4:0]  active;
  logic        fired;
  logic [10:0] xs [5];
  logic [10:0] ys [5];

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int          cyc;
    int          slot;
    logic [10:0] x;
    logic [10:0] y;
  } exp_t;
  exp_t exp_q[$];

  enemy_missile_ctl #(
    .FIRE_PERIOD(32'd100), .MOVE_DIV(32'd10), .SPEED(11'd4), .X_OFFSET(11'd14),
    .Y_OFFSET(11'd32), .Y_BOTTOM(11'd767), .PARK(11'h7FF)
  ) dut (
    .pclk(pclk), .rst(rst), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_alive(enemy_alive), .ship_down(ship_down),
    .en_x_missile1(x1), .en_x_missile2(x2), .en_x_missile3(x3),
    .en_x_missile4(x4), .en_x_missile5(x5),
    .en_y_missile1(y1), .en_y_missile2(y2), .en_y_missile3(y3),
    .en_y_missile4(y4), .en_y_missile5(y5),
    .active(active), .fired(fired)
  );

  assign xs[0] = x1; assign xs[1] = x2; assign xs[2] = x3; assign xs[3] = x4; assign xs[4] = x5;
  assign ys[0] = y1; assign ys[1] = y2; assign ys[2] = y3; assign ys[3] = y4; assign ys[4] = y5;

  always #5 pclk = ~pclk;

  // Cycles since reset release: value seen at the negedge after edge n is n
  always @(posedge pclk) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, expv);
  endtask

  task automatic wait_until(input int n);
    for (int i = 0; i < 5000 && cyc < n; i++) @(negedge pclk);
    if (cyc != n) check("wait_timeout", 32'(cyc), 32'(n));
  endtask

  task automatic push_launch(input int c, input int s, input logic [10:0] ex, input logic [10:0] ey);
    exp_t e;
    e.cyc = c; e.slot = s; e.x = ex; e.y = ey;
    exp_q.push_back(e);
  endtask

  task automatic check_all_park(input string name);
    for (int k = 0; k < 5; k++) begin
      check({name, "_x"}, 32'(xs[k]), 32'h7FF);
      check({name, "_y"}, 32'(ys[k]), 32'h7FF);
    end
  endtask

  // Monitor: each fired pulse must match the next queued launch
  always @(negedge pclk) begin
    if (rst === 1'b1) begin
      if (fired) begin
        if (exp_q.size() == 0) begin
          check("unexpected_fired", 32'(cyc), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("launch_cyc", 32'(cyc), 32'(e.cyc));
          check("launch_active", 32'(active[e.slot]), 32'd1);
          check("launch_x", 32'(xs[e.slot]), 32'(e.x));
          check("launch_y", 32'(ys[e.slot]), 32'(e.y));
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("missing_fired", 32'(fired), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0; enemy_x = 11'd200; enemy_y = 11'd100; enemy_alive = 1'b1; ship_down = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check_all_park("reset");
    check("reset_active", 32'(active), 32'd0);
    check("reset_fired", 32'(fired), 32'd0);
    rst = 1'b1;

    // Three launches, then ship_down with three flying
    push_launch(100, 0, 11'd214, 11'd132);
    push_launch(200, 1, 11'd214, 11'd132);
    push_launch(300, 2, 11'd214, 11'd132);
    wait_until(110);
    check("step_y", 32'(y1), 32'd136);
    check("step_x", 32'(x1), 32'd214);
    wait_until(350);
    check("three_active", 32'(active), 32'b00111);
    check("slot1_y_350", 32'(y1), 32'd132 + 32'd4 * 32'd25);
    ship_down = 1'b1;
    wait_until(351);
    check("down_active", 32'(active), 32'd0);
    check_all_park("down");
    wait_until(380);
    ship_down = 1'b0;

    // Refill all five slots; sixth tick is dropped
    push_launch(480, 0, 11'd214, 11'd132);
    push_launch(580, 1, 11'd314, 11'd82);
    push_launch(680, 2, 11'd214, 11'd132);
    push_launch(780, 3, 11'd214, 11'd132);
    push_launch(880, 4, 11'd214, 11'd132);
    wait_until(479);
    check("no_fire_before_480", 32'(active), 32'd0);
    wait_until(550);
    enemy_x = 11'd300; enemy_y = 11'd50;
    wait_until(600);
    enemy_x = 11'd200; enemy_y = 11'd100;
    wait_until(980);
    check("full_active", 32'(active), 32'b11111);
    check("slot1_y_980", 32'(y1), 32'd332);
    check("slot2_y_980", 32'(y2), 32'd242);
    check("slot2_x_980", 32'(x2), 32'd314);

    // Reset mid-flight
    wait_until(985);
    rst = 1'b0;
    repeat (3) @(negedge pclk);
    check("midreset_active", 32'(active), 32'd0);
    check_all_park("midreset");
    enemy_alive = 1'b0;
    rst = 1'b1;
    wait_until(101);
    check("dead_enemy_no_launch", 32'(active), 32'd0);

    // Saturated x, retire boundary at 764 -> 768
    wait_until(150);
    enemy_alive = 1'b1; enemy_x = 11'd2040; enemy_y = 11'd732;
    push_launch(200, 0, 11'h7FE, 11'd764);
    wait_until(209);
    check("y764_active", 32'(active), 32'd1);
    check("y764_y", 32'(y1), 32'd764);
    wait_until(210);
    check("retire768_active", 32'(active), 32'd0);
    check("retire768_x", 32'(x1), 32'h7FF);
    check("retire768_y", 32'(y1), 32'h7FF);

    // 763 -> 767 stays flying, then 771 retires
    wait_until(250);
    enemy_x = 11'd10; enemy_y = 11'd731;
    push_launch(300, 0, 11'd24, 11'd763);
    wait_until(310);
    check("y767_active", 32'(active), 32'd1);
    check("y767_y", 32'(y1), 32'd767);
    wait_until(320);
    check("retire771_active", 32'(active), 32'd0);

    // Saturated y launch retires on its first step
    wait_until(350);
    enemy_x = 11'd0; enemy_y = 11'd2040;
    push_launch(400, 0, 11'd14, 11'h7FE);
    wait_until(410);
    check("sat_y_retire", 32'(active), 32'd0);
    wait_until(420);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
